// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared register-file geometry and dump FSM encodings.
// Used by reg_dump_unit and reg_dump_last_finder.
package reg_dump_pkg;

  localparam int REG_COUNT    = 16;
  localparam int REG_SIZE     = 8;
  localparam int REG_PTR_SIZE = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/reg_dump_last_finder.sv
// reg_dump_last_finder: flags when no mask bit is set above the pointer.
// Purely combinational; drives the last-word marker of the dump stream.
module reg_dump_last_finder #(
  parameter int REG_COUNT    = 16,
  parameter int REG_PTR_SIZE = 4
) (
  input  logic [REG_COUNT-1:0]    i_mask,
  input  logic [REG_PTR_SIZE-1:0] i_ptr,
  output logic                    o_last
);

  always_comb begin
    o_last = 1'b1;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (i > int'(i_ptr) && i_mask[i]) begin
        o_last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_dump_unit.sv
// reg_dump_unit: walks the register file and streams (index, data) words.
// Optional XOR checksum output under REG_DUMP_CHECKSUM_EN.
module reg_dump_unit #(
  parameter int REG_COUNT    = reg_dump_pkg::REG_COUNT,
  parameter int REG_SIZE     = reg_dump_pkg::REG_SIZE,
  parameter int REG_PTR_SIZE = reg_dump_pkg::REG_PTR_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dump_start,
  input  logic [REG_COUNT-1:0]    dump_mask,
  output logic                    busy,
  output logic                    done,
  output logic [REG_PTR_SIZE-1:0] rf_rd_ptr,
  input  logic [REG_SIZE-1:0]     rf_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [REG_PTR_SIZE-1:0] out_idx,
  output logic [REG_SIZE-1:0]     out_data,
  output logic                    out_last
`ifdef REG_DUMP_CHECKSUM_EN
  ,
  output logic [REG_SIZE-1:0]     dump_checksum
`endif
);

  import reg_dump_pkg::*;

  logic [1:0]              r_state;
  logic [REG_PTR_SIZE-1:0] r_ptr;
  logic [REG_COUNT-1:0]    r_mask;
  logic                    r_valid;
  logic [REG_PTR_SIZE-1:0] r_idx;
  logic [REG_SIZE-1:0]     r_data;
  logic                    r_last;

  logic w_free;
  logic w_hs;
  logic w_sel;
  logic w_last;
  logic w_start;

  assign w_free  = !r_valid || out_ready;
  assign w_hs    = r_valid && out_ready;
  assign w_sel   = r_mask[r_ptr];
  assign w_start = (r_state == S_IDLE) && dump_start;

  reg_dump_last_finder #(
    .REG_COUNT    (REG_COUNT),
    .REG_PTR_SIZE (REG_PTR_SIZE)
  ) u_last (
    .i_mask (r_mask),
    .i_ptr  (r_ptr),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_mask  <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      if (w_hs) begin
        r_valid <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (dump_start) begin
            r_mask  <= dump_mask;
            r_ptr   <= '0;
            r_state <= (|dump_mask) ? S_SCAN : S_DONE;
          end
        end
        S_SCAN: begin
          if (!w_sel) begin
            r_ptr <= r_ptr + 1'b1;
          end else if (w_free) begin
            r_valid <= 1'b1;
            r_idx   <= r_ptr;
            r_data  <= rf_rd_data;
            r_last  <= w_last;
            if (w_last) begin
              r_state <= S_DRAIN;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end
        // leave once the final word has been taken and out_valid is low
        S_DRAIN: begin
          if (!r_valid) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [REG_SIZE-1:0] r_csum;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_csum <= '0;
    end else if (w_start) begin
      r_csum <= '0;
    end else if (w_hs) begin
      r_csum <= r_csum ^ r_data;
    end
  end

  assign dump_checksum = r_csum;
`endif

  assign busy      = (r_state == S_SCAN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign rf_rd_ptr = r_ptr;
  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign out_data  = r_data;
  assign out_last  = r_last;

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: scoreboard bench for reg_dump_unit.
// Checksum checks compile in when REG_DUMP_CHECKSUM_EN is defined.
module tb_reg_dump_unit;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] data;
    logic       last;
  } word_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        dump_start;
  logic [15:0] dump_mask;
  logic        busy;
  logic        done;
  logic [3:0]  rf_rd_ptr;
  logic [7:0]  rf_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic [7:0]  out_data;
  logic        out_last;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0]  dump_checksum;
`endif

  logic [7:0] rf [16];
  assign rf_rd_data = rf[rf_rd_ptr];

  reg_dump_unit dut (
    .clk        (clk),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_mask  (dump_mask),
    .busy       (busy),
    .done       (done),
    .rf_rd_ptr  (rf_rd_ptr),
    .rf_rd_data (rf_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_data   (out_data),
    .out_last   (out_last)
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    .dump_checksum (dump_checksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  word_t      exp_q[$];
  logic [7:0] exp_cs_q[$];

  int    rmode = 0;
  int    first_cyc;
  int    done_cyc;
  int    busy_cnt;
  int    done_total = 0;
  bit    done_seen;
  bit    valid_seen;
  bit    prev_stall = 0;
  word_t prev_w;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int highest(input logic [15:0] m);
    for (int i = 15; i >= 0; i--) if (m[i]) return i;
    return -1;
  endfunction

  // reference: one word per set bit, ascending, last on the top bit
  task automatic model_push(input logic [15:0] m);
    int         h;
    logic [7:0] cs;
    word_t      w;
    h  = highest(m);
    cs = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        w.idx  = 4'(i);
        w.data = rf[i];
        w.last = (i == h);
        exp_q.push_back(w);
        cs ^= rf[i];
      end
    end
    exp_cs_q.push_back(cs);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    word_t w;
    if (reset !== 1'b1) begin
      prev_stall = 0;
    end else begin
      busy_cnt += int'(busy);
      if (out_valid) begin
        valid_seen = 1;
        if (first_cyc < 0) first_cyc = cyc;
      end
      if (prev_stall) begin
        chk("stall_hold", {out_valid, out_idx, out_data, out_last},
            {1'b1, prev_w});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got idx %0h data %0h expected none",
                   out_idx, out_data);
        end else begin
          w = exp_q.pop_front();
          chk("word", {out_idx, out_data, out_last}, w);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_w     = {out_idx, out_data, out_last};
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        done_total++;
        chk("done_words_left", exp_q.size(), 0);
        chk("done_busy_valid", {busy, out_valid}, 0);
        if (exp_cs_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
          chk("checksum", dump_checksum, exp_cs_q.pop_front());
`else
          void'(exp_cs_q.pop_front());
`endif
        end
      end
    end
  end

  // call just after a posedge; returns on the posedge ending the done cycle
  task automatic run_dump(input logic [15:0] m, input int mode,
                          input bit ign);
    int tstart;
    int k;
    int h;
    rmode = mode;
    model_push(m);
    #1;
    dump_start = 1'b1;
    dump_mask  = m;
    first_cyc  = -1;
    busy_cnt   = 0;
    valid_seen = 0;
    done_seen  = 0;
    @(posedge clk);
    #1;
    tstart     = cyc;
    dump_start = 1'b0;
    dump_mask  = 16'($urandom);
    if (ign) begin
      repeat (3) @(posedge clk);
      #1;
      dump_start = 1'b1;
      dump_mask  = 16'h00F0;
      @(posedge clk);
      #1;
      dump_start = 1'b0;
    end
    for (int n = 0; n < 400 && !done_seen; n++) @(posedge clk);
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done mask %0h", m);
      exp_q.delete();
      exp_cs_q.delete();
      return;
    end
    k = lowest(m);
    h = highest(m);
    if (m == 16'h0) begin
      chk("zero_done_time", done_cyc - tstart, 0);
      chk("zero_busy", busy_cnt, 0);
      chk("zero_valid", 32'(valid_seen), 0);
    end else if (mode == 0) begin
      chk("first_word_time", first_cyc - tstart, k + 1);
      chk("done_time", done_cyc - tstart, h + 3);
      chk("busy_cycles", busy_cnt, h + 3);
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk(nm, {busy, done, out_valid, out_idx, out_data, out_last, rf_rd_ptr},
        0);
  endtask

  initial begin
    int base;
    reset      = 1'b0;
    dump_start = 1'b0;
    dump_mask  = 16'h0;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset_state");
    #1 reset = 1'b1;

    for (int i = 0; i < 16; i++) rf[i] = 8'(8'h10 + i);
    @(posedge clk);
    run_dump(16'hFFFF, 0, 0);
    run_dump(16'h8005, 1, 0);
    run_dump(16'h0000, 0, 0);
    run_dump(16'hFFFF, 0, 1);
    run_dump(16'h0081, 0, 0);

    // abort a dump mid-scan with reset
    rmode = 0;
    model_push(16'hFFFF);
    #1;
    dump_start = 1'b1;
    dump_mask  = 16'hFFFF;
    @(posedge clk);
    #1 dump_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    exp_cs_q.delete();
    base = done_total;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk_zero_outputs("reset_mid_scan");
    end
    #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("reset_no_done", done_total - base, 0);
    chk("reset_idle", {busy, out_valid}, 0);
    @(posedge clk);

`ifdef REG_DUMP_CHECKSUM_EN
    rf[1] = 8'hA5;
    rf[3] = 8'h0F;
    run_dump(16'h000A, 0, 0);
`endif

    for (int t = 0; t < 25; t++) begin
      logic [15:0] m;
      for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
      m = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      run_dump(m, int'($urandom_range(0, 2)), 0);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
- Read-side debug/readback engine for the core register file. It is the reader counterpart to the writeback and init_R0 write paths.
- On a start pulse it walks the register file through one combinational read port and emits the selected registers as (index, data) words on a valid/ready stream.
- Sits beside the core pipeline and shares a register-file read pointer mux with decode. The core grants the port while busy=1.

Parameters:
- REG_COUNT, 16, number of architectural registers (matches shared constant).
- REG_SIZE, 8, register width in bits.
- REG_PTR_SIZE, 4, register index width; must satisfy 2^REG_PTR_SIZE >= REG_COUNT.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low (reset asserted when 0, sampled on posedge clk).
- dump_start  in  1  one-cycle request; sampled only in IDLE.
- dump_mask  in  REG_COUNT  bit i set = emit register i; latched with dump_start.
- busy  out  1  dump in progress (SCAN or DRAIN).
- done  out  1  one-cycle pulse when a dump completes.
- rf_rd_ptr  out  REG_PTR_SIZE  register file read pointer; read data is combinational.
- rf_rd_data  in  REG_SIZE  r[rf_rd_ptr].
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word when valid & ready.
- out_idx  out  REG_PTR_SIZE  register index of the current word.
- out_data  out  REG_SIZE  register value captured at load time.
- out_last  out  1  current word is the highest set bit of the latched mask.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, ptr=0, mask_q=0. All outputs 0: busy, done, out_valid, out_idx, out_data, out_last, rf_rd_ptr. Reset during any state aborts the dump immediately; no done pulse.
- States:
  - IDLE: busy=0. On dump_start=1 at edge T, latch mask_q=dump_mask and ptr=0.
    - Nonzero mask: go to SCAN; busy=1 from T+1.
    - Zero mask: go to DONE; done=1 at T+1, busy stays 0, no words emitted.
  - SCAN: rf_rd_ptr=ptr. Slot is free when out_valid=0 or out_ready=1.
    - mask_q[ptr]=0: ptr++.
    - mask_q[ptr]=1 and slot free: load out_idx=ptr, out_data=rf_rd_data, out_valid=1, and out_last=(no set bit above ptr). If last, go to DRAIN; otherwise ptr++.
    - mask_q[ptr]=1 and slot full: hold ptr; rf_rd_ptr stays stable.
  - DRAIN: wait for valid & ready on the final word, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, out_valid=0; next state IDLE.
- Throughput: one word per cycle with out_ready held high. Consecutive set bits give back-to-back words; each cleared bit costs one scan cycle.
- Latency: the first word is valid at T+2+k, where k is the index of the lowest set bit.
- Stream rules: while out_valid=1 and out_ready=0, out_idx, out_data and out_last hold stable. out_valid drops the cycle after the final handshake unless a new word loads in the same edge.
- Snapshot semantics: each word carries the register value at its load edge, not at dump_start. Writes to a register after its load are not reflected.
- dump_start while busy or in DONE is ignored. A dump_start in the cycle after done is accepted.
- ptr never exceeds REG_COUNT-1; no wrap-around, because the last set bit always exits to DRAIN.
- dump_mask bits are used only at the start edge; later changes have no effect.

Optional Feature:
- Macro REG_DUMP_CHECKSUM_EN.
- Defined: adds output dump_checksum (REG_SIZE bits). It is cleared to 0 at the start edge and XOR-accumulates out_data on every handshake. It is valid and stable while done=1 and holds until the next start. Reset value is 0; zero mask gives 0.
- Undefined: no port and no accumulator logic.

Decomposition:
- Shared constants header: REG_COUNT, REG_SIZE, REG_PTR_SIZE, plus the FSM state encodings (IDLE, SCAN, DRAIN, DONE) as localparams.
- One natural sub-module: reg_dump_last_finder, a combinational "any set bit above ptr" detector over mask_q that produces out_last.
- Everything else lives in reg_dump_unit.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-SCAN with mask=16'hFFFF -> all outputs 0, no done pulse, IDLE after release.
- Full dump: registers preloaded r[i]=8'h10+i, mask=16'hFFFF, out_ready=1, start at T -> words idx 0..15 on T+2..T+17 with data 8'h10..8'h1F, out_last only at idx 15, done at T+19, busy high T+1..T+18.
- Sparse mask with backpressure: mask=16'h8005, out_ready toggling 1/0 -> words idx 0, 2, 15 only. Data, idx and last stay stable during ready=0 cycles; last=1 on idx 15.
- Zero mask: dump_start with mask=0 -> done=1 at T+1, busy never 1, out_valid never 1.
- Ignored start: pulse dump_start mid-dump with a different mask -> original sequence unchanged. A start one cycle after done begins a new dump.
- Checksum (REG_DUMP_CHECKSUM_EN): r[1]=8'hA5, r[3]=8'h0F, mask=16'h000A -> dump_checksum=8'hAA while done=1.
